writeback_pipe: RTL and testbench

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

---
 rtl/writeback_pipe.sv | 151 +++++++++++++++
 tb/tb_writeback_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | writeback_pipe: result select/load format into a 2-entry skid buffer
// | Rev 1.0
// +-----------------------------------------------------------------------------
module writeback_pipe #(
  parameter int DATA_SIZE = 32,
  parameter int NUM_REGS  = 32,
  parameter int NUM_SRC   = 3,
  parameter int LOAD_SRC  = 1,
  localparam int SW = $clog2(NUM_SRC),
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                         i_aclk,
  input  logic                         i_areset_n,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [RW-1:0]                i_rdest,
  input  logic                         i_cu_regwrite,
  input  logic [SW-1:0]                i_src_sel,
  input  logic [NUM_SRC*DATA_SIZE-1:0] i_src_data,
  input  logic [1:0]                   i_ld_size,
  input  logic                         i_ld_unsigned,
  input  logic [1:0]                   i_ld_offset,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [RW-1:0]                o_rdest,
  output logic                         o_cu_regwrite,
  output logic [DATA_SIZE-1:0]         o_wb_result,
  output logic [63:0]                  o_instret
);

  localparam logic [SW-1:0] c_load_sel = SW'(LOAD_SRC);

  logic [DATA_SIZE-1:0] w_sel_data;
  logic [DATA_SIZE-1:0] w_load;
  logic [DATA_SIZE-1:0] w_result;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic                 w_regwrite;

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_src_sel == SW'(k)) w_sel_data = i_src_data[k*DATA_SIZE +: DATA_SIZE];
    end
  end

  always_comb begin
    w_byte = w_sel_data[{i_ld_offset, 3'b000} +: 8];
    w_half = w_sel_data[{i_ld_offset[1], 4'b0000} +: 16];
    case (i_ld_size)
      2'b00:   w_load = {{(DATA_SIZE-8){~i_ld_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{(DATA_SIZE-16){~i_ld_unsigned & w_half[15]}}, w_half};
      default: w_load = w_sel_data;
    endcase
    w_result   = (i_src_sel == c_load_sel) ? w_load : w_sel_data;
    w_regwrite = i_cu_regwrite & (i_rdest != '0);
  end

  logic                 r_valid;
  logic                 r_skid_valid;
  logic                 r_ready;
  logic [RW-1:0]        r_rdest;
  logic                 r_regwrite;
  logic [DATA_SIZE-1:0] r_result;
  logic [RW-1:0]        r_skid_rdest;
  logic                 r_skid_regwrite;
  logic [DATA_SIZE-1:0] r_skid_result;
  logic [63:0]          r_instret;

  logic w_in_hs, w_out_hs;
  logic w_valid_nxt, w_skid_nxt;
  logic w_load_main, w_load_skid, w_skid_to_main;

  // Skid occupancy blocks input (r_ready == ~r_skid_valid), so an input
  // handshake only ever arrives with the skid slot empty.
  always_comb begin
    w_in_hs        = i_valid & r_ready;
    w_out_hs       = r_valid & i_ready;
    w_valid_nxt    = r_valid;
    w_skid_nxt     = r_skid_valid;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (i_flush) begin
      w_valid_nxt = 1'b0;
      w_skid_nxt  = 1'b0;
    end else if (r_skid_valid) begin
      if (w_out_hs) begin
        w_skid_to_main = 1'b1;
        w_skid_nxt     = 1'b0;
        w_valid_nxt    = 1'b1;
      end
    end else if (w_in_hs) begin
      if (!r_valid || i_ready) begin
        w_load_main = 1'b1;
        w_valid_nxt = 1'b1;
      end else begin
        w_load_skid = 1'b1;
        w_skid_nxt  = 1'b1;
      end
    end else if (w_out_hs) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_valid         <= 1'b0;
      r_skid_valid    <= 1'b0;
      r_ready         <= 1'b1;
      r_rdest         <= '0;
      r_regwrite      <= 1'b0;
      r_result        <= '0;
      r_skid_rdest    <= '0;
      r_skid_regwrite <= 1'b0;
      r_skid_result   <= '0;
      r_instret       <= '0;
    end else begin
      r_valid      <= w_valid_nxt;
      r_skid_valid <= w_skid_nxt;
      r_ready      <= ~w_skid_nxt;
      if (w_load_main) begin
        r_rdest    <= i_rdest;
        r_regwrite <= w_regwrite;
        r_result   <= w_result;
      end else if (w_skid_to_main) begin
        r_rdest    <= r_skid_rdest;
        r_regwrite <= r_skid_regwrite;
        r_result   <= r_skid_result;
      end
      if (w_load_skid) begin
        r_skid_rdest    <= i_rdest;
        r_skid_regwrite <= w_regwrite;
        r_skid_result   <= w_result;
      end
      if (w_out_hs) r_instret <= r_instret + 64'd1;
    end
  end

  assign o_ready       = r_ready;
  assign o_valid       = r_valid;
  assign o_rdest       = r_rdest;
  assign o_cu_regwrite = r_valid & r_regwrite;
  assign o_wb_result   = r_result;
  assign o_instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_writeback_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | tb_writeback_pipe: directed vectors for writeback_pipe
// | Rev 1.0
// +-----------------------------------------------------------------------------
module tb_writeback_pipe;

  logic        i_aclk = 1'b0;
  logic        i_areset_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [4:0]  i_rdest = '0;
  logic        i_cu_regwrite = 1'b0;
  logic [1:0]  i_src_sel = '0;
  logic [95:0] i_src_data = '0;
  logic [1:0]  i_ld_size = '0;
  logic        i_ld_unsigned = 1'b0;
  logic [1:0]  i_ld_offset = '0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [4:0]  o_rdest;
  logic        o_cu_regwrite;
  logic [31:0] o_wb_result;
  logic [63:0] o_instret;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_aclk = ~i_aclk;

  writeback_pipe dut (
    .i_aclk        (i_aclk),
    .i_areset_n    (i_areset_n),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_rdest       (i_rdest),
    .i_cu_regwrite (i_cu_regwrite),
    .i_src_sel     (i_src_sel),
    .i_src_data    (i_src_data),
    .i_ld_size     (i_ld_size),
    .i_ld_unsigned (i_ld_unsigned),
    .i_ld_offset   (i_ld_offset),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_rdest       (o_rdest),
    .o_cu_regwrite (o_cu_regwrite),
    .o_wb_result   (o_wb_result),
    .o_instret     (o_instret)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Non-selected sources carry distinct filler so a wrong mux lane shows up.
  task automatic drive(input logic [4:0] rd, input logic rw, input logic [1:0] sel,
                       input logic [31:0] d, input logic [1:0] sz, input logic uns,
                       input logic [1:0] off);
    i_rdest       = rd;
    i_cu_regwrite = rw;
    i_src_sel     = sel;
    i_src_data    = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    if (sel < 2'd3) i_src_data[sel*32 +: 32] = d;
    i_ld_size     = sz;
    i_ld_unsigned = uns;
    i_ld_offset   = off;
    i_valid       = 1'b1;
  endtask

  task automatic step();
    @(posedge i_aclk);
    @(negedge i_aclk);
  endtask

  initial begin
    @(negedge i_aclk);
    check("rst_valid",   {63'd0, o_valid}, 64'd0);
    check("rst_ready",   {63'd0, o_ready}, 64'd1);
    check("rst_rw",      {63'd0, o_cu_regwrite}, 64'd0);
    check("rst_rdest",   {59'd0, o_rdest}, 64'd0);
    check("rst_result",  {32'd0, o_wb_result}, 64'd0);
    check("rst_instret", o_instret, 64'd0);

    i_areset_n = 1'b1;
    drive(5'd5, 1'b1, 2'd1, 32'h80FF_7F01, 2'b00, 1'b0, 2'd3);
    step();
    check("first_accept", {63'd0, o_valid}, 64'd1);
    check("byte_signed",  {32'd0, o_wb_result}, 64'hFFFF_FF80);
    check("byte_rdest",   {59'd0, o_rdest}, 64'd5);
    check("byte_rw",      {63'd0, o_cu_regwrite}, 64'd1);
    drive(5'd5, 1'b1, 2'd1, 32'h80FF_7F01, 2'b00, 1'b1, 2'd3);
    step();
    check("byte_unsigned", {32'd0, o_wb_result}, 64'h0000_0080);
    check("stream_instret1", o_instret, 64'd1);
    drive(5'd6, 1'b1, 2'd1, 32'h8001_1234, 2'b01, 1'b0, 2'd3);
    step();
    check("half_signed", {32'd0, o_wb_result}, 64'hFFFF_8001);
    drive(5'd6, 1'b1, 2'd1, 32'hDEAD_BEEF, 2'b10, 1'b0, 2'd2);
    step();
    check("word_load", {32'd0, o_wb_result}, 64'hDEAD_BEEF);
    drive(5'd0, 1'b1, 2'd0, 32'h0000_1234, 2'b00, 1'b0, 2'd1);
    step();
    check("x0_rw",     {63'd0, o_cu_regwrite}, 64'd0);
    check("x0_result", {32'd0, o_wb_result}, 64'h0000_1234);
    check("x0_valid",  {63'd0, o_valid}, 64'd1);
    drive(5'd7, 1'b1, 2'd2, 32'hCAFE_F00D, 2'b00, 1'b0, 2'd1);
    step();
    check("src2_result", {32'd0, o_wb_result}, 64'hCAFE_F00D);
    check("src2_rw",     {63'd0, o_cu_regwrite}, 64'd1);
    drive(5'd9, 1'b1, 2'd3, 32'h0, 2'b10, 1'b0, 2'd0);
    step();
    check("sel_range", {32'd0, o_wb_result}, 64'd0);
    i_valid = 1'b0;
    step();
    check("drain_valid", {63'd0, o_valid}, 64'd0);
    check("drain_rw",    {63'd0, o_cu_regwrite}, 64'd0);
    check("drain_instret", o_instret, 64'd7);

    // Backpressure: A to main, B to skid, C held upstream.
    i_ready = 1'b0;
    drive(5'd1, 1'b1, 2'd0, 32'h111, 2'b10, 1'b0, 2'd0);
    step();
    check("bp_a_ready", {63'd0, o_ready}, 64'd1);
    drive(5'd2, 1'b1, 2'd0, 32'h222, 2'b10, 1'b0, 2'd0);
    step();
    check("bp_full_ready", {63'd0, o_ready}, 64'd0);
    drive(5'd3, 1'b1, 2'd0, 32'h333, 2'b10, 1'b0, 2'd0);
    step();
    check("bp_hold_ready",  {63'd0, o_ready}, 64'd0);
    check("bp_hold_result", {32'd0, o_wb_result}, 64'h111);
    check("bp_hold_rdest",  {59'd0, o_rdest}, 64'd1);
    i_ready = 1'b1;
    step();
    check("bp_b_result",  {32'd0, o_wb_result}, 64'h222);
    check("bp_b_rdest",   {59'd0, o_rdest}, 64'd2);
    check("bp_b_ready",   {63'd0, o_ready}, 64'd1);
    check("bp_b_instret", o_instret, 64'd8);
    step();
    i_valid = 1'b0;
    check("bp_c_result",  {32'd0, o_wb_result}, 64'h333);
    check("bp_c_valid",   {63'd0, o_valid}, 64'd1);
    step();
    check("bp_end_valid", {63'd0, o_valid}, 64'd0);
    check("bp_end_instret", o_instret, 64'd10);

    // Flush with both slots full plus an offered entry.
    i_ready = 1'b0;
    drive(5'd1, 1'b1, 2'd0, 32'h444, 2'b10, 1'b0, 2'd0);
    step();
    drive(5'd2, 1'b1, 2'd0, 32'h555, 2'b10, 1'b0, 2'd0);
    step();
    drive(5'd3, 1'b1, 2'd0, 32'h666, 2'b10, 1'b0, 2'd0);
    i_flush = 1'b1;
    step();
    check("flush2_valid",   {63'd0, o_valid}, 64'd0);
    check("flush2_ready",   {63'd0, o_ready}, 64'd1);
    check("flush2_instret", o_instret, 64'd10);
    // Flush beats an accepted input handshake.
    drive(5'd4, 1'b1, 2'd0, 32'h777, 2'b10, 1'b0, 2'd0);
    step();
    check("flush_in_valid", {63'd0, o_valid}, 64'd0);
    i_flush = 1'b0;
    i_ready = 1'b1;
    drive(5'd5, 1'b1, 2'd0, 32'h888, 2'b10, 1'b0, 2'd0);
    step();
    check("post_flush_result", {32'd0, o_wb_result}, 64'h888);
    i_valid = 1'b0;
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    check("flush_out_valid",   {63'd0, o_valid}, 64'd0);
    check("flush_out_instret", o_instret, 64'd11);

    // Async reset while skid is full.
    i_ready = 1'b0;
    drive(5'd1, 1'b1, 2'd0, 32'h999, 2'b10, 1'b0, 2'd0);
    step();
    drive(5'd2, 1'b1, 2'd0, 32'hAAA, 2'b10, 1'b0, 2'd0);
    step();
    i_valid = 1'b0;
    check("pre_rst_ready", {63'd0, o_ready}, 64'd0);
    #2 i_areset_n = 1'b0;
    #1;
    check("arst_valid",   {63'd0, o_valid}, 64'd0);
    check("arst_ready",   {63'd0, o_ready}, 64'd1);
    check("arst_rw",      {63'd0, o_cu_regwrite}, 64'd0);
    check("arst_rdest",   {59'd0, o_rdest}, 64'd0);
    check("arst_result",  {32'd0, o_wb_result}, 64'd0);
    check("arst_instret", o_instret, 64'd0);
    @(negedge i_aclk);
    i_areset_n = 1'b1;
    dut.r_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    i_ready = 1'b1;
    drive(5'd4, 1'b1, 2'd0, 32'hBBB, 2'b10, 1'b0, 2'd0);
    step();
    i_valid = 1'b0;
    check("wrap_valid",   {63'd0, o_valid}, 64'd1);
    check("wrap_pre",     o_instret, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("wrap_instret", o_instret, 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
